// File: rtl/uart_pkg.sv
// Shared types and constants for the instruction-load UART transmit path.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  function automatic int clks_per_bit(input int clk_hz, input int bit_rate);
    return clk_hz / bit_rate;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock word FIFO; pointers carry one extra wrap bit to tell full from empty.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full)
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop && !empty)
      rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: only slots between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push && !full)
      mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_word_tx.sv
// 8N1 transmitter that buffers 32-bit words and sends each as four bytes, LSB byte first.
// word_valid/word_ready: a word is taken on a rising edge where both are high; ready depends only on FIFO fullness.
module uart_word_tx
  import uart_pkg::*;
#(
  parameter int CLK_HZ       = 50000000,
  parameter int BIT_RATE     = 9600,
  parameter int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BIT_RATE),
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_tx_en,
  input  logic        word_valid,
  input  logic [31:0] word_data,
  output logic        word_ready,
  output logic        uart_txd,
  output logic        uart_tx_busy,
  output logic        word_done
);

  localparam int WORD_W = UART_DATA_BITS * BYTES_PER_WORD;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(UART_DATA_BITS);
  localparam int IDX_W  = $clog2(BYTES_PER_WORD);

  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE = BAUD_W'(1);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(UART_DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  BIT_ONE  = BIT_W'(1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(BYTES_PER_WORD - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);

  tx_state_e          state_q, state_d;
  logic [BAUD_W-1:0]  baud_q, baud_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WORD_W-1:0]  shift_q, shift_d;
  logic               txd_q, txd_d;
  logic               done_pend_q, done_pend_d;
  logic               word_done_q;

  logic               fifo_pop, fifo_full, fifo_empty, fifo_push;
  logic [WORD_W-1:0]  fifo_rdata;
  logic               baud_tick, try_launch;
  logic [IDX_W-1:0]   launch_idx;
  logic [7:0]         cur_byte;

  assign fifo_push = word_valid && !fifo_full;

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (word_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign cur_byte = shift_q[idx_q*UART_DATA_BITS +: UART_DATA_BITS];

  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    done_pend_d = 1'b0;
    fifo_pop    = 1'b0;
    try_launch  = 1'b0;
    launch_idx  = idx_q;
    baud_tick   = (baud_q == '0);
    txd_d       = 1'b1;

    case (state_q)
      IDLE: try_launch = 1'b1;
      START: begin
        txd_d = 1'b0;
        if (baud_tick) begin
          state_d = DATA;
          bit_d   = '0;
          baud_d  = BAUD_MAX;
        end else begin
          baud_d = baud_q - BAUD_ONE;
        end
      end
      DATA: begin
        txd_d = cur_byte[bit_q];
        if (baud_tick) begin
          baud_d = BAUD_MAX;
          if (bit_q == BIT_LAST)
            state_d = STOP;
          else
            bit_d = bit_q + BIT_ONE;
        end else begin
          baud_d = baud_q - BAUD_ONE;
        end
      end
      STOP: begin
        if (baud_tick) begin
          idx_d       = idx_q + IDX_ONE;
          launch_idx  = idx_q + IDX_ONE;
          done_pend_d = (idx_q == IDX_LAST);
          state_d     = IDLE;
          baud_d      = BAUD_MAX;
          try_launch  = 1'b1;
        end else begin
          baud_d = baud_q - BAUD_ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A nonzero index means the shift register still holds unsent bytes of the current word.
    if (try_launch && uart_tx_en) begin
      if (launch_idx != '0) begin
        state_d = START;
        baud_d  = BAUD_MAX;
      end else if (!fifo_empty) begin
        fifo_pop = 1'b1;
        shift_d  = fifo_rdata;
        state_d  = START;
        baud_d   = BAUD_MAX;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      txd_q       <= 1'b1;
      done_pend_q <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      txd_q       <= txd_d;
      done_pend_q <= done_pend_d;
      word_done_q <= done_pend_q;
    end
  end

  // The line is registered one cycle behind the FSM, so word_done is delayed to match.
  assign uart_txd     = txd_q;
  assign word_done    = word_done_q;
  assign word_ready   = !fifo_full;
  assign uart_tx_busy = (state_q != IDLE) || !fifo_empty || (idx_q != '0);

endmodule

// File: tb/tb_uart_word_tx.sv
// Scoreboard bench for uart_word_tx: a line monitor decodes 8N1 frames and compares them with expected bytes.
`timescale 1ns/1ps
module tb_uart_word_tx;

  localparam int CLK_HZ   = 50000000;
  localparam int BIT_RATE = 5000000;

  logic        clk = 1'b0;
  logic        rst;
  logic        uart_tx_en;
  logic        word_valid;
  logic [31:0] word_data;
  logic        word_ready;
  logic        uart_txd;
  logic        uart_tx_busy;
  logic        word_done;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int push_cyc = 0;

  logic [7:0] exp_q[$];
  int         start_log[$];
  int         done_log[$];
  int         frames_done = 0;

  int         mon_cnt = 0;
  logic       mon_busy = 1'b0;
  logic [7:0] mon_byte = '0;
  logic [7:0] exp_b;

  logic [31:0] burst_w [5];
  int base_s, base_d, base_f, en_cyc, snap;

  uart_word_tx #(
    .CLK_HZ     (CLK_HZ),
    .BIT_RATE   (BIT_RATE),
    .FIFO_DEPTH (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .uart_tx_en   (uart_tx_en),
    .word_valid   (word_valid),
    .word_data    (word_data),
    .word_ready   (word_ready),
    .uart_txd     (uart_txd),
    .uart_tx_busy (uart_tx_busy),
    .word_done    (word_done)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic sb_push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
  endtask

  // ---------------- line monitor (samples mid-bit on the falling edge) ----------------
  always @(negedge clk) begin
    if (rst) begin
      mon_busy = 1'b0;
    end else if (!mon_busy) begin
      if (uart_txd === 1'b0) begin
        mon_busy = 1'b1;
        mon_cnt  = 0;
        start_log.push_back(cyc);
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == 5) begin
        check("start_bit", {31'd0, uart_txd}, 32'd0);
      end else if (mon_cnt > 5 && mon_cnt < 90 && (mon_cnt % 10) == 5) begin
        mon_byte = {uart_txd, mon_byte[7:1]};
      end else if (mon_cnt == 95) begin
        check("stop_bit", {31'd0, uart_txd}, 32'd1);
        check("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          exp_b = exp_q.pop_front();
          check("frame_byte", {24'd0, mon_byte}, {24'd0, exp_b});
        end
        frames_done++;
        mon_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && word_done === 1'b1) done_log.push_back(cyc);
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic push_word(input logic [31:0] w);
    word_valid = 1'b1;
    word_data  = w;
    check("push_ready", {31'd0, word_ready}, 32'd1);
    tick();
    push_cyc   = cyc;
    word_valid = 1'b0;
    sb_push_word(w);
  endtask

  task automatic wait_starts(input int target, input int budget);
    int n = 0;
    while (start_log.size() < target && n < budget) begin tick(); n++; end
    check("start_count", start_log.size(), target);
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames_done < target && n < budget) begin tick(); n++; end
    check("frame_count", frames_done, target);
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_log.size() < target && n < budget) begin tick(); n++; end
    check("done_count", done_log.size(), target);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    burst_w[0] = 32'h00c58533;
    burst_w[1] = 32'hdeadbeef;
    burst_w[2] = 32'h13579bdf;
    burst_w[3] = 32'h80000001;
    burst_w[4] = 32'h55aa33cc;

    rst = 1'b1; uart_tx_en = 1'b0; word_valid = 1'b0; word_data = '0;
    wait_cycles(5);
    rst = 1'b0;
    check("rst_txd", {31'd0, uart_txd}, 32'd1);
    check("rst_ready", {31'd0, word_ready}, 32'd1);
    check("rst_busy", {31'd0, uart_tx_busy}, 32'd0);
    check("rst_done", {31'd0, word_done}, 32'd0);

    // single word, start bit two cycles after the push edge
    uart_tx_en = 1'b1;
    base_s = start_log.size(); base_d = done_log.size();
    push_word(32'hfb010113);
    wait_starts(base_s + 1, 50);
    check("start_latency", start_log[base_s] - push_cyc, 2);
    wait_done(base_d + 1, 1000);
    check("done_latency", done_log[base_d] - start_log[base_s], 400);
    wait_cycles(20);
    check("single_idle_busy", {31'd0, uart_tx_busy}, 32'd0);
    check("single_done_once", done_log.size(), base_d + 1);

    // fill FIFO while disabled; fifth word must be refused
    uart_tx_en = 1'b0;
    base_s = start_log.size(); base_d = done_log.size();
    for (int i = 0; i < 5; i++) begin
      word_valid = 1'b1;
      word_data  = burst_w[i];
      check("burst_accept", {31'd0, word_ready}, (i < 4) ? 32'd1 : 32'd0);
      if (i < 4) sb_push_word(burst_w[i]);
      tick();
    end
    word_valid = 1'b0;
    check("burst_ready_low", {31'd0, word_ready}, 32'd0);
    wait_cycles(30);
    check("burst_held", start_log.size(), base_s);
    uart_tx_en = 1'b1;
    wait_done(base_d + 4, 2500);
    check("burst_len", done_log[base_d + 3] - start_log[base_s], 1600);
    check("burst_frames", start_log.size() - base_s, 16);
    wait_cycles(20);

    // enable dropped during byte 1
    base_s = start_log.size(); base_d = done_log.size(); base_f = frames_done;
    push_word(32'h04812623);
    wait_starts(base_s + 2, 300);
    uart_tx_en = 1'b0;
    wait_frames(base_f + 2, 300);
    wait_cycles(50);
    check("gate_line_idle", {31'd0, uart_txd}, 32'd1);
    check("gate_busy", {31'd0, uart_tx_busy}, 32'd1);
    check("gate_no_more", start_log.size(), base_s + 2);
    check("gate_no_done", done_log.size(), base_d);
    uart_tx_en = 1'b1;
    en_cyc = cyc;
    wait_done(base_d + 1, 500);
    check("resume_latency", start_log[base_s + 2] - en_cyc, 2);
    wait_cycles(20);

    // reset in the middle of data bit 3 of byte 0
    base_s = start_log.size();
    push_word(32'h12345678);
    push_word(32'h9abcdef0);
    wait_starts(base_s + 1, 50);
    while (cyc < start_log[base_s] + 44) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check("mrst_txd", {31'd0, uart_txd}, 32'd1);
    check("mrst_busy", {31'd0, uart_tx_busy}, 32'd0);
    check("mrst_ready", {31'd0, word_ready}, 32'd1);
    snap = start_log.size();
    base_d = done_log.size();
    wait_cycles(200);
    check("mrst_flushed", start_log.size(), snap);
    push_word(32'h00000000);
    wait_done(base_d + 1, 600);
    wait_cycles(20);

    // FIFO full, pop and offered push on the same edge
    uart_tx_en = 1'b0;
    base_d = done_log.size();
    for (int i = 0; i < 4; i++) push_word(burst_w[(i + 1) % 5]);
    check("pp_full", {31'd0, word_ready}, 32'd0);
    uart_tx_en = 1'b1;
    word_valid = 1'b1;
    word_data  = 32'hcafef00d;
    check("pp_ready_before", {31'd0, word_ready}, 32'd0);
    tick();
    check("pp_ready_after", {31'd0, word_ready}, 32'd1);
    tick();
    word_valid = 1'b0;
    sb_push_word(32'hcafef00d);
    wait_done(base_d + 5, 2500);
    wait_cycles(20);

    check("end_sb_empty", exp_q.size(), 0);
    check("end_busy", {31'd0, uart_tx_busy}, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_word_tx.md
Name: uart_word_tx

Overview:
- 8N1 UART transmitter, the send side of the instruction-load UART link.
- Accepts 32-bit words from the SoC side and buffers them in a small word FIFO.
- Serialises each word as 4 bytes, least-significant byte first ([7:0], [15:8], [23:16], [31:24]).
- Byte order matches the receiver/loader on the far end, so a word written here is reassembled identically.

Parameters:
- CLK_HZ, 50000000: system clock frequency in Hz.
- BIT_RATE, 9600: UART bit rate in bit/s.
- CLKS_PER_BIT, CLK_HZ/BIT_RATE (integer division, 5208 at defaults): clocks per UART bit. Must be >= 2.
- FIFO_DEPTH, 4: word FIFO depth. Power of 2, >= 2.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- uart_tx_en  in  1  transmit enable; gates the start of each new byte
- word_valid  in  1  word_data is valid this cycle
- word_data  in  32  word to transmit
- word_ready  out  1  FIFO can accept a word (not full)
- uart_txd  out  1  UART transmit line, idle high
- uart_tx_busy  out  1  a frame is in progress or FIFO is non-empty
- word_done  out  1  one-cycle pulse when the stop bit of byte 3 of a word completes

Behaviour:
- Reset (rst=1 at a clk edge) forces the following on the next cycle:
  - uart_txd=1, word_ready=1, uart_tx_busy=0, word_done=0.
  - FIFO empty, FSM in IDLE, bit counter, byte index and baud counter cleared.
- Reset mid-frame aborts the frame immediately; no partial stop bit is sent.
- Push: when word_valid && word_ready. word_ready = !full, registered.
  - word_valid while full is ignored; the word is dropped and the producer must hold it.
  - A pop in the same cycle does not enable a push that cycle; ready rises the following cycle.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START when a byte is available and uart_tx_en=1. A byte is available when byte index > 0 (word in shift register), or FIFO is non-empty (pop into 32-bit shift register, byte index=0).
  - START: uart_txd=0 for CLKS_PER_BIT cycles -> DATA.
  - DATA: 8 bits, bit 0 first, each held CLKS_PER_BIT cycles -> STOP.
  - STOP: uart_txd=1 for CLKS_PER_BIT cycles. On exit, byte index increments mod 4.
    - If index wraps 3->0: word_done pulses for 1 cycle, word retires.
  - STOP -> START with no idle gap when the next byte is available and uart_tx_en=1; otherwise -> IDLE.
- Latency: word pushed at edge N into empty FIFO with FSM idle and uart_tx_en=1:
  - pop at edge N+1, uart_txd falls at edge N+2.
- Frame timing:
  - one byte = exactly 10*CLKS_PER_BIT cycles.
  - back-to-back word = 40*CLKS_PER_BIT cycles.
- uart_tx_en=0 never truncates a byte in progress. It holds the FSM in IDLE between bytes, including mid-word (byte index preserved).
- uart_tx_busy = (state != IDLE) || FIFO non-empty || byte index != 0.
- Baud counter is a down-counter loaded with CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT). No drift across bytes: the reload happens on the same cycle as the state/bit advance.
- FIFO pointers are $clog2(FIFO_DEPTH)+1 bits and wrap naturally. full = MSBs differ and LSBs equal.

Decomposition:
- Package uart_pkg:
  - tx state enum (IDLE/START/DATA/STOP).
  - function clks_per_bit(CLK_HZ, BIT_RATE).
  - constants UART_DATA_BITS=8, BYTES_PER_WORD=4.
- Sub-module sync_fifo, parameterised WIDTH=32 and DEPTH=FIFO_DEPTH.
  - Same clk/rst.
  - Ports: push, pop, wdata, rdata, full, empty.
- Top contains the FSM, baud counter and shift register.

Test Plan (bench uses CLK_HZ=50000000, BIT_RATE=5000000 -> CLKS_PER_BIT=10):
- Reset: hold rst 5 cycles, release.
  -> uart_txd=1, word_ready=1, uart_tx_busy=0, word_done=0.
- Single word: push 32'hfb010113, uart_tx_en=1.
  -> line bytes 0x13, 0x01, 0x01, 0xfb, LSB first, 10 cycles/bit.
  -> start bit begins 2 cycles after push.
  -> word_done pulses once, 400 cycles after start.
- Full FIFO: push 5 words back-to-back while uart_tx_en=0.
  -> word_ready low after 4th push; 5th word not accepted.
  -> raise en: 4 words emitted with no inter-frame gaps, 1600 cycles total, 4 word_done pulses.
- Enable gating mid-word: push 32'h04812623, drop uart_tx_en during byte 1 (0x26).
  -> byte 0x26 completes, line idles high.
  -> re-enable 50 cycles later: bytes 0x81, 0x04 follow, then word_done.
- Reset mid-frame: assert rst during the DATA bit 3 of byte 0.
  -> uart_txd=1 next cycle, FIFO empty, busy=0.
  -> new push 32'h00000000 sends 4 clean frames.
- Simultaneous push/pop when full: FIFO full, pop occurs the same cycle a 5th word is offered.
  -> word not accepted that cycle; word_ready=1 the next cycle and the word is accepted then.
